// File: rtl/axilite_pkg.sv
// Shared AXI4-Lite definitions: response codes, bridge FSM states and default widths.
package axilite_pkg;

    localparam int DEF_ADDR_WIDTH    = 32;
    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_ERR_CNT_WIDTH = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WR_ADDR_DATA = 3'd1,
        ST_WR_RESP      = 3'd2,
        ST_RD_ADDR      = 3'd3,
        ST_RD_DATA      = 3'd4,
        ST_RESP         = 3'd5
    } bridge_state_t;

endpackage

// File: rtl/axilite_master_bridge.sv
// Single-outstanding AXI4-Lite master driven by a valid/ready request/response port.
// All AXI outputs are decoded from registered state, so none depends combinationally on an input.
module axilite_master_bridge
    import axilite_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ERR_CNT_WIDTH = DEF_ERR_CNT_WIDTH
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic [ERR_CNT_WIDTH-1:0]  err_count,
    output logic                      AWVALID,
    input  logic                      AWREADY,
    output logic [ADDR_WIDTH-1:0]     AWADDR,
    output logic                      WVALID,
    input  logic                      WREADY,
    output logic [DATA_WIDTH-1:0]     WDATA,
    output logic [DATA_WIDTH/8-1:0]   WSTRB,
    input  logic                      BVALID,
    output logic                      BREADY,
    input  logic [1:0]                BRESP,
    output logic                      ARVALID,
    input  logic                      ARREADY,
    output logic [ADDR_WIDTH-1:0]     ARADDR,
    input  logic                      RVALID,
    output logic                      RREADY,
    input  logic [DATA_WIDTH-1:0]     RDATA,
    input  logic [1:0]                RRESP
);

    bridge_state_t               state;
    logic                        aw_done;
    logic                        w_done;
    logic [ADDR_WIDTH-1:0]       addr_q;
    logic [DATA_WIDTH-1:0]       wdata_q;
    logic [DATA_WIDTH/8-1:0]     wstrb_q;

    logic                        aw_next;
    logic                        w_next;
    logic                        capture;
    logic [1:0]                  resp_in;

    localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE = {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = {ERR_CNT_WIDTH{1'b1}};

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign AWVALID   = (state == ST_WR_ADDR_DATA) && !aw_done;
    assign WVALID    = (state == ST_WR_ADDR_DATA) && !w_done;
    assign BREADY    = (state == ST_WR_RESP);
    assign ARVALID   = (state == ST_RD_ADDR);
    assign RREADY    = (state == ST_RD_DATA);
    assign AWADDR    = addr_q;
    assign ARADDR    = addr_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;

    // A channel counts as done once its handshake has happened, including this cycle's.
    assign aw_next = aw_done || AWREADY;
    assign w_next  = w_done  || WREADY;
    assign capture = ((state == ST_WR_RESP) && BVALID) || ((state == ST_RD_DATA) && RVALID);
    assign resp_in = (state == ST_WR_RESP) ? BRESP : RRESP;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state     <= ST_IDLE;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rsp_rdata <= '0;
            rsp_resp  <= RESP_OKAY;
            err_count <= '0;
        end else begin
            if (capture && (resp_in != RESP_OKAY) && (err_count != ERR_MAX))
                err_count <= err_count + ERR_ONE;

            case (state)
                ST_IDLE: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        wstrb_q <= req_wstrb;
                        state   <= req_write ? ST_WR_ADDR_DATA : ST_RD_ADDR;
                    end
                end
                ST_WR_ADDR_DATA: begin
                    if (aw_next && w_next) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= ST_WR_RESP;
                    end else begin
                        aw_done <= aw_next;
                        w_done  <= w_next;
                    end
                end
                ST_WR_RESP: begin
                    if (BVALID) begin
                        rsp_resp  <= BRESP;
                        rsp_rdata <= '0;
                        state     <= ST_RESP;
                    end
                end
                ST_RD_ADDR: begin
                    if (ARREADY)
                        state <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (RVALID) begin
                        rsp_resp  <= RRESP;
                        rsp_rdata <= RDATA;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/axilite_master_bridge.md
Name: axilite_master_bridge

Overview:
Single-outstanding AXI4-Lite master. It converts a simple valid/ready request/response interface from the emulator side into AXI4-Lite read and write transactions. It is the initiator counterpart to the RTL-adapter AXI-Lite slave top, and lets the emulator or a test harness drive any AXI-Lite slave in the same design. An error counter is included for debug.

Parameters:
ADDR_WIDTH, 32, width of req_addr, AWADDR and ARADDR
DATA_WIDTH, 32, width of data buses; must be 32 or 64; strobe width is DATA_WIDTH/8
ERR_CNT_WIDTH, 8, width of the saturating error counter

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESETn  in  1  reset, synchronous, active-low
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  byte address, passed through unmodified
req_wdata  in  DATA_WIDTH  write data
req_wstrb  in  DATA_WIDTH/8  write byte strobes
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
rsp_resp  out  2  BRESP or RRESP of the completed transaction
err_count  out  ERR_CNT_WIDTH  saturating count of non-OKAY responses
AWVALID/AWREADY/AWADDR  out/in/out  1/1/ADDR_WIDTH  write address channel
WVALID/WREADY/WDATA/WSTRB  out/in/out/out  1/1/DATA_WIDTH/DATA_WIDTH/8  write data channel
BVALID/BREADY/BRESP  in/out/in  1/1/2  write response channel
ARVALID/ARREADY/ARADDR  out/in/out  1/1/ADDR_WIDTH  read address channel
RVALID/RREADY/RDATA/RRESP  in/out/in/in  1/1/DATA_WIDTH/2  read data channel

Behaviour:
- Reset (ARESETn = 0 at a rising edge of ACLK):
  - state = IDLE.
  - AWVALID, WVALID, ARVALID, BREADY, RREADY and rsp_valid = 0.
  - rsp_rdata = 0, rsp_resp = 0, err_count = 0.
  - The aw_done and w_done flags are cleared.
- Reset mid-transaction: the transaction is abandoned, and all VALID/READY outputs are low after that edge.
- req_ready = 1 only in IDLE, decoded from registered state. No other output combinationally depends on an input.
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE:
  - On req accept, capture addr, wdata, wstrb and write into registers.
  - If write, go to WR_ADDR_DATA; otherwise go to RD_ADDR.
- WR_ADDR_DATA:
  - AWVALID = !aw_done and WVALID = !w_done; both rise on the cycle after accept.
  - An AWREADY handshake sets aw_done and drops AWVALID on the next edge. W is handled the same way, independently; either may complete first, or both in the same cycle.
  - When both are done, go to WR_RESP.
- WR_RESP:
  - BREADY = 1.
  - On BVALID, capture BRESP into rsp_resp, set rsp_rdata = 0, and go to RESP.
- RD_ADDR: ARVALID = 1; on ARREADY, go to RD_DATA.
- RD_DATA:
  - RREADY = 1.
  - On RVALID, capture RDATA and RRESP and go to RESP.
- RESP:
  - rsp_valid = 1, with data held stable until rsp_ready.
  - On rsp_ready, go to IDLE; req_ready is high on the following cycle.
- AXI stability: while any VALID is high, its payload is constant and VALID is never withdrawn before READY.
- READY ordering: BREADY and RREADY assert only in their wait states. The block never depends on slave READY arriving before VALID.
- Minimum latency with an always-ready slave, accept at cycle 0:
  - Write: AW/W handshake at cycle 1, B handshake at cycle 2, rsp_valid at cycle 3.
  - Read: AR handshake at cycle 1, R handshake at cycle 2, rsp_valid at cycle 3.
- err_count increments by 1 when a response is captured with resp != 2'b00 (EXOKAY 2'b01 also counts). It saturates at all-ones and never wraps.
- Throughput: one transaction outstanding; requests are not accepted outside IDLE.

Decomposition:
- Shared package axilite_pkg:
  - Response codes RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
  - FSM state enum for the six states.
  - Default width constants.
- No sub-module; the FSM and channel registers are a single module.

Test Plan:
- Write, slave always ready: req addr 0x0000_0010, wdata 0xDEADBEEF, wstrb 0xF -> AWADDR 0x10 and WDATA 0xDEADBEEF at cycle 1; rsp_valid at cycle 3 with rsp_resp 0, rsp_rdata 0.
- Read with slave returning 0x12345678 and RRESP 0, ARREADY delayed 3 cycles -> ARVALID held high with ARADDR stable for 4 cycles; rsp_rdata 0x12345678.
- Write with WREADY at cycle 1 and AWREADY at cycle 4 -> WVALID drops after cycle 1, AWVALID held until cycle 4, BREADY first high at cycle 5.
- BRESP = SLVERR on 300 consecutive writes -> err_count saturates at 255; rsp_resp = 2'b10 each time.
- rsp_ready held low for 5 cycles -> rsp_valid and payload stable for 5 cycles; req_ready stays 0 until 1 cycle after rsp_ready.
- ARESETn low during RD_DATA -> ARVALID/RREADY/rsp_valid are 0 after that edge; req_ready is 1 after reset release.
